// File: rtl/seg7_disp_if.sv
// Requester-side bundle for the seven-segment display arbiter.
interface seg7_disp_if;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 32;

    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic                    i_force_en;
    logic [SEL_W-1:0]        i_force_sel;
    logic [DATA_W-1:0]       o_disp_data;
    logic [N_REQ-1:0]        o_grant;
    logic [SEL_W-1:0]        o_owner;
    logic                    o_valid;

    modport master (
        output i_req, i_data, i_force_en, i_force_sel,
        input  o_disp_data, o_grant, o_owner, o_valid
    );

    modport slave (
        input  i_req, i_data, i_force_en, i_force_sel,
        output o_disp_data, o_grant, o_owner, o_valid
    );
endinterface

// File: rtl/seg7_disp_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among four
// sources, with a bounded dwell per owner and a manual override.
module seg7_disp_arbiter #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic        clk,
    input  logic        rstn,
    seg7_disp_if.slave  bus
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_FORCE} state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [N_REQ-1:0]    grant_q, grant_n;
    logic [SEL_W-1:0]    owner_q, owner_n;
    logic                valid_q, valid_n;
    logic [DATA_W-1:0]   disp_q, disp_n;

    logic                take;
    logic [SEL_W-1:0]    win;
    logic [N_REQ-1:0]    others;

    // First set bit of req searching upward from last+1, owner position last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        rr_pick = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        grant_n = grant_q;
        owner_n = owner_q;
        valid_n = valid_q;
        disp_n  = disp_q;
        take    = 1'b0;
        win     = owner_q;
        others  = bus.i_req & ~(N_REQ'(1) << owner_q);

        if (bus.i_force_en) begin
            state_n = S_FORCE;
            grant_n = N_REQ'(1) << bus.i_force_sel;
            owner_n = bus.i_force_sel;
            valid_n = 1'b1;
            disp_n  = bus.i_data[bus.i_force_sel*DATA_W +: DATA_W];
        end else begin
            case (state_q)
                S_IDLE: begin
                    grant_n = '0;
                    valid_n = 1'b0;
                    if (bus.i_req != '0) begin
                        take = 1'b1;
                        win  = rr_pick(bus.i_req, owner_q);
                    end
                end
                S_OWN: begin
                    disp_n = bus.i_data[owner_q*DATA_W +: DATA_W];
                    if (cnt_q != '0) cnt_n = cnt_q - CNT_W'(1);
                    if (!bus.i_req[owner_q]) begin
                        if (bus.i_req != '0) begin
                            take = 1'b1;
                            win  = rr_pick(bus.i_req, owner_q);
                        end else begin
                            state_n = S_IDLE;
                            grant_n = '0;
                            valid_n = 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        if (others != '0) begin
                            take = 1'b1;
                            win  = rr_pick(others, owner_q);
                        end else begin
                            cnt_n = RELOAD;
                        end
                    end
                end
                default: begin
                    // Leaving override: one blank cycle before arbitration resumes.
                    state_n = S_IDLE;
                    grant_n = '0;
                    valid_n = 1'b0;
                end
            endcase

            if (take) begin
                state_n = S_OWN;
                cnt_n   = RELOAD;
                grant_n = N_REQ'(1) << win;
                owner_n = win;
                valid_n = 1'b1;
                disp_n  = bus.i_data[win*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers; owner doubles as the round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= SEL_W'(N_REQ - 1);
            valid_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            grant_q <= grant_n;
            owner_q <= owner_n;
            valid_q <= valid_n;
            disp_q  <= disp_n;
        end
    end

    assign bus.o_disp_data = disp_q;
    assign bus.o_grant     = grant_q;
    assign bus.o_owner     = owner_q;
    assign bus.o_valid     = valid_q;
endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with a 4-cycle dwell.
module tb_seg7_disp_arbiter;
    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    seg7_disp_if bus();

    seg7_disp_arbiter #(
        .DWELL_CYCLES (4),
        .CNT_W        (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic [3:0]  exp_g;
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        bus.i_req       = 4'b0000;
        bus.i_force_en  = 1'b0;
        bus.i_force_sel = 2'd0;
        for (int k = 0; k < 4; k++) bus.i_data[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);

        // 1: reset then idle
        repeat (3) tick();
        rstn = 1'b1;
        repeat (10) tick();
        check("rst_grant", 32'(bus.o_grant), 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_data",  bus.o_disp_data,  32'h0);
        check("rst_owner", 32'(bus.o_owner), 32'h3);

        // 2: two requesters rotate every dwell period
        bus.i_req = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            tick();
            exp_g = (((c / 4) % 2) == 0) ? 4'b0001 : 4'b0100;
            exp_d = (((c / 4) % 2) == 0) ? 32'hA0A0_0000 : 32'hA0A0_0002;
            check($sformatf("rr_grant_c%0d", c), 32'(bus.o_grant), 32'(exp_g));
            check($sformatf("rr_data_c%0d", c),  bus.o_disp_data,  exp_d);
            check($sformatf("rr_valid_c%0d", c), 32'(bus.o_valid), 32'h1);
        end

        // 3: owner 2 releases while source 1 waits, then everyone releases
        tick();
        check("own2_grant", 32'(bus.o_grant), 32'h4);
        bus.i_req = 4'b0010;
        tick();
        check("rel_grant", 32'(bus.o_grant), 32'h2);
        check("rel_data",  bus.o_disp_data,  32'hA0A0_0001);
        check("rel_owner", 32'(bus.o_owner), 32'h1);
        bus.i_req = 4'b0000;
        tick();
        check("idle_valid", 32'(bus.o_valid), 32'h0);
        check("idle_grant", 32'(bus.o_grant), 32'h0);
        check("idle_data",  bus.o_disp_data,  32'hA0A0_0001);

        // 4: override mid-dwell, then release
        bus.i_req = 4'b1111;
        tick();
        check("all_grant", 32'(bus.o_grant), 32'h4);
        tick();
        check("all_hold", 32'(bus.o_grant), 32'h4);
        bus.i_force_en  = 1'b1;
        bus.i_force_sel = 2'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("frc_grant_c%0d", c), 32'(bus.o_grant), 32'h8);
            check($sformatf("frc_data_c%0d", c),  bus.o_disp_data,  32'hA0A0_0003);
        end
        check("frc_owner", 32'(bus.o_owner), 32'h3);
        check("frc_valid", 32'(bus.o_valid), 32'h1);
        bus.i_force_en = 1'b0;
        tick();
        check("unfrc_valid", 32'(bus.o_valid), 32'h0);
        check("unfrc_grant", 32'(bus.o_grant), 32'h0);
        check("unfrc_data",  bus.o_disp_data,  32'hA0A0_0003);
        tick();
        check("post_grant", 32'(bus.o_grant), 32'h1);
        check("post_data",  bus.o_disp_data,  32'hA0A0_0000);

        // 5: live data update from the owner
        bus.i_req = 4'b0010;
        tick();
        check("own1_grant", 32'(bus.o_grant), 32'h2);
        check("own1_data",  bus.o_disp_data,  32'hA0A0_0001);
        bus.i_data[32 +: 32] = 32'h1234_5678;
        tick();
        check("live_data",  bus.o_disp_data,  32'h1234_5678);
        check("live_grant", 32'(bus.o_grant), 32'h2);

        // 6: asynchronous reset between edges
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_grant", 32'(bus.o_grant), 32'h0);
        check("arst_valid", 32'(bus.o_valid), 32'h0);
        check("arst_data",  bus.o_disp_data,  32'h0);
        check("arst_owner", 32'(bus.o_owner), 32'h3);
        bus.i_data[32 +: 32] = 32'hA0A0_0001;
        bus.i_req = 4'b0110;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("arst_first_grant", 32'(bus.o_grant), 32'h2);
        check("arst_first_owner", 32'(bus.o_owner), 32'h1);
        check("arst_first_data",  bus.o_disp_data,  32'hA0A0_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
